// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace-tree multiply-accumulate block:
// parameter defaults, the controller state type and the constant
// functions that size the carry-save reduction tree.
package wallace_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_ACC_WIDTH   = 24;
    localparam int DEFAULT_APPROX_COLS = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    // Rows left after one 3:2 compression stage on n rows.
    function automatic int next_rows(input int n);
        return (n <= 2) ? n : 2 * (n / 3) + (n % 3);
    endfunction

    // Row count entering stage s of a tree that starts with n rows.
    function automatic int rows_at_stage(input int n, input int s);
        int r;
        r = n;
        for (int k = 0; k < 32; k++) begin
            if (k < s) r = next_rows(r);
        end
        return r;
    endfunction

    // Number of compression stages needed to bring n rows down to two.
    function automatic int num_stages(input int n);
        int r;
        int s;
        r = n;
        s = 0;
        for (int k = 0; k < 32; k++) begin
            if (r > 2) begin
                r = next_rows(r);
                s++;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/wallace_reduction.sv
// One-bit adder cells and the combinational Wallace reduction of the
// WIDTH x WIDTH partial-product matrix down to a sum row and a carry row.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module wallace_reduction
    import wallace_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int APPROX_COLS = DEFAULT_APPROX_COLS
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx_en,
    output logic [2*WIDTH-1:0] sum,
    output logic [2*WIDTH-1:0] carry
);
    localparam int PW     = 2 * WIDTH;
    localparam int NUM_ST = num_stages(WIDTH);
    localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << APPROX_COLS;

    // Carries out of the top column are dropped: the true product always
    // fits in PW bits, so the row total is only needed modulo 2**PW.
    logic [PW-1:0] mask;
    logic [PW-1:0] rows [NUM_ST+1][WIDTH];

    assign mask = approx_en ? KEEP_MASK : {PW{1'b1}};

    for (genvar j = 0; j < WIDTH; j++) begin : g_pp
        assign rows[0][j] = (PW'(a & {WIDTH{b[j]}}) << j) & mask;
    end

    for (genvar s = 0; s < NUM_ST; s++) begin : g_stage
        localparam int N = rows_at_stage(WIDTH, s);
        localparam int G = N / 3;
        localparam int M = next_rows(N);

        for (genvar g = 0; g < G; g++) begin : g_fa
            logic [PW-1:0] fa_sum;
            logic [PW-1:0] fa_carry;
            logic          carry_unused;
            for (genvar k = 0; k < PW; k++) begin : g_bit
                full_adder u_fa (
                    .a   (rows[s][3*g][k]),
                    .b   (rows[s][3*g+1][k]),
                    .cin (rows[s][3*g+2][k]),
                    .sum (fa_sum[k]),
                    .cout(fa_carry[k])
                );
            end
            assign rows[s+1][2*g]   = fa_sum;
            assign rows[s+1][2*g+1] = {fa_carry[PW-2:0], 1'b0};
            assign carry_unused     = fa_carry[PW-1];
        end

        if (N % 3 == 1) begin : g_pass
            assign rows[s+1][2*G] = rows[s][3*G];
        end else if (N % 3 == 2) begin : g_ha
            logic [PW-1:0] ha_sum;
            logic [PW-1:0] ha_carry;
            logic          carry_unused;
            for (genvar k = 0; k < PW; k++) begin : g_bit
                half_adder u_ha (
                    .a   (rows[s][3*G][k]),
                    .b   (rows[s][3*G+1][k]),
                    .sum (ha_sum[k]),
                    .cout(ha_carry[k])
                );
            end
            assign rows[s+1][2*G]   = ha_sum;
            assign rows[s+1][2*G+1] = {ha_carry[PW-2:0], 1'b0};
            assign carry_unused     = ha_carry[PW-1];
        end

        for (genvar r = M; r < WIDTH; r++) begin : g_zero
            assign rows[s+1][r] = '0;
        end
    end

    assign sum   = rows[NUM_ST][0];
    assign carry = rows[NUM_ST][1];

endmodule

// File: rtl/wallace_tree_mac.sv
// Three-stage unsigned multiply-accumulate: operand register, Wallace
// reduction register, then CPA plus saturating accumulator with a
// two-state controller that holds each dot-product result until taken.
module wallace_tree_mac
    import wallace_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
    parameter int APPROX_COLS = DEFAULT_APPROX_COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);
    localparam int PW  = 2 * WIDTH;
    localparam int AW1 = ACC_WIDTH + 1;

    mac_state_t state;

    logic               accept;
    logic               s1_valid;
    logic               s1_last;
    logic               s1_approx;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [PW-1:0]      red_sum;
    logic [PW-1:0]      red_carry;
    logic               s2_valid;
    logic               s2_last;
    logic [PW-1:0]      s2_sum;
    logic [PW-1:0]      s2_carry;
    logic [PW-1:0]      product;
    logic [AW1-1:0]     acc_sum;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic               acc_ovf;
    logic               ovf_next;

    // Once a last-tagged pair is in flight nothing from the next dot product
    // may enter, so the result and the fresh accumulator never mix.
    assign in_ready = (state == ACCUM) && !(s1_valid && s1_last) && !(s2_valid && s2_last);
    assign accept   = in_valid && in_ready;

    // Stage 1: capture the accepted operand pair with its tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_last   <= in_last;
                s1_approx <= approx_en;
            end
        end
    end

    wallace_reduction #(
        .WIDTH      (WIDTH),
        .APPROX_COLS(APPROX_COLS)
    ) u_reduction (
        .a        (s1_a),
        .b        (s1_b),
        .approx_en(s1_approx),
        .sum      (red_sum),
        .carry    (red_carry)
    );

    // Stage 2: register the reduced sum and carry rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= red_sum;
                s2_carry <= red_carry;
                s2_last  <= s1_last;
            end
        end
    end

    // Stage 3 datapath: final carry-propagate add and saturating accumulate.
    always_comb begin
        product  = s2_sum + s2_carry;
        acc_sum  = {1'b0, acc} + AW1'(product);
        acc_next = acc_sum[ACC_WIDTH-1:0];
        ovf_next = acc_ovf;
        if (acc_sum[ACC_WIDTH]) begin
            acc_next = {ACC_WIDTH{1'b1}};
            ovf_next = 1'b1;
        end
    end

    // Controller: accumulate pairs leaving stage 2, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (s2_valid) begin
                        acc     <= acc_next;
                        acc_ovf <= ovf_next;
                        if (s2_last) begin
                            out_acc   <= acc_next;
                            out_ovf   <= ovf_next;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        acc_ovf   <= 1'b0;
                        state     <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_tree_mac.sv
// Directed bench for wallace_tree_mac: a default instance (24-bit
// accumulator) and a 16-bit accumulator instance share the same stimulus.
module tb_wallace_tree_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        approx_en;
    logic        out_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;

    logic        in_ready;
    logic        out_valid;
    logic        out_ovf;
    logic [23:0] out_acc;

    logic        in_ready16;
    logic        out_valid16;
    logic        out_ovf16;
    logic [15:0] out_acc16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wallace_tree_mac dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .approx_en(approx_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_ovf  (out_ovf)
    );

    wallace_tree_mac #(.ACC_WIDTH(16)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready16),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .approx_en(approx_en),
        .out_valid(out_valid16),
        .out_ready(out_ready),
        .out_acc  (out_acc16),
        .out_ovf  (out_ovf16)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one pair at a negedge and let the next posedge accept it.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last, input logic approx);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        approx_en = approx;
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the negedge of the cycle after acceptance; counts the cycle
    // in which out_valid is first seen, relative to the accept cycle.
    task automatic waitResult(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("result_within_budget", 32'(out_valid), 32'd1);
    endtask

    task automatic takeResult();
        out_ready = 1'b1;
        checkOutput("out_valid_at_handshake", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_after_handshake", 32'(out_valid), 32'd0);
        checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int  cyc;
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        approx_en = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_acc", 32'(out_acc), 32'd0);
        checkOutput("reset_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Exact 255 x 255 and first-to-result latency
        applyStimulus(8'd255, 8'd255, 1'b1, 1'b0);
        checkOutput("in_ready_low_after_last", 32'(in_ready), 32'd0);
        waitResult(cyc);
        checkOutput("latency", 32'(cyc), 32'd3);
        checkOutput("exact_255x255", 32'(out_acc), 32'd65025);
        checkOutput("exact_ovf", 32'(out_ovf), 32'd0);
        checkOutput("in_ready_in_hold", 32'(in_ready), 32'd0);
        takeResult();

        // Approximate 255 x 255: 49 worth of low columns dropped
        applyStimulus(8'd255, 8'd255, 1'b1, 1'b1);
        waitResult(cyc);
        checkOutput("approx_255x255", 32'(out_acc), 32'd64976);
        takeResult();

        // Dot product 3*4 + (bubble) + 5*6 + 7*8 = 98
        applyStimulus(8'd3, 8'd4, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(8'd5, 8'd6, 1'b0, 1'b0);
        applyStimulus(8'd7, 8'd8, 1'b1, 1'b0);
        checkOutput("in_ready_low_after_last_b2b", 32'(in_ready), 32'd0);
        waitResult(cyc);
        checkOutput("dot_98", 32'(out_acc), 32'd98);

        // Hold for 5 cycles with a pending pair offered
        in_valid = 1'b1;
        in_a     = 8'd9;
        in_b     = 8'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_out_acc", 32'(out_acc), 32'd98);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        takeResult();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checkOutput("no_result_from_blocked_pair", 32'(seen), 32'd0);

        // Saturation on the 16-bit accumulator, exact sum on the 24-bit one
        applyStimulus(8'd255, 8'd255, 1'b0, 1'b0);
        applyStimulus(8'd255, 8'd255, 1'b1, 1'b0);
        waitResult(cyc);
        checkOutput("sat_acc16", 32'(out_acc16), 32'd65535);
        checkOutput("sat_ovf16", 32'(out_ovf16), 32'd1);
        checkOutput("wide_acc24", 32'(out_acc), 32'd130050);
        checkOutput("wide_ovf24", 32'(out_ovf), 32'd0);
        takeResult();
        applyStimulus(8'd2, 8'd2, 1'b1, 1'b0);
        waitResult(cyc);
        checkOutput("after_sat_acc16", 32'(out_acc16), 32'd4);
        checkOutput("after_sat_ovf16", 32'(out_ovf16), 32'd0);
        checkOutput("after_sat_acc24", 32'(out_acc), 32'd4);
        takeResult();

        // Reset with two pairs in flight
        applyStimulus(8'd10, 8'd10, 1'b0, 1'b0);
        applyStimulus(8'd20, 8'd20, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | out_valid;
            @(negedge clk);
        end
        checkOutput("no_result_after_reset", 32'(seen), 32'd0);
        applyStimulus(8'd1, 8'd1, 1'b1, 1'b0);
        waitResult(cyc);
        checkOutput("post_reset_1x1", 32'(out_acc), 32'd1);
        takeResult();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
